// File: rtl/mux29_pkg.sv
// Shared constants, FSM state type and the fixed select codes for the
// irregular upper channels of the 29:1 tree mux.
package mux29_pkg;
  localparam int NUM_CH = 29;
  localparam int SEL_W  = 8;
  localparam int CH_W   = 5;

  localparam logic [CH_W-1:0] LAST_CH = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Channels 21..28 sit on the ragged edge of the tree and have hand-assigned codes
  localparam logic [SEL_W-1:0] SEL_CH21 = 8'h08;
  localparam logic [SEL_W-1:0] SEL_CH22 = 8'h18;
  localparam logic [SEL_W-1:0] SEL_CH23 = 8'h48;
  localparam logic [SEL_W-1:0] SEL_CH24 = 8'h54;
  localparam logic [SEL_W-1:0] SEL_CH25 = 8'h58;
  localparam logic [SEL_W-1:0] SEL_CH26 = 8'h20;
  localparam logic [SEL_W-1:0] SEL_CH27 = 8'h60;
  localparam logic [SEL_W-1:0] SEL_CH28 = 8'h80;
endpackage

// File: rtl/mux29_scan_ctrl_if.sv
// Request/result bundle between a requester and the scan controller,
// including the tree-mux select and sampled output.
interface mux29_scan_ctrl_if;
  import mux29_pkg::*;

  logic              start;
  logic              mode;
  logic [CH_W-1:0]   ch_idx;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_bit;
  logic [NUM_CH-1:0] scan_word;

  modport master (
    output start, mode, ch_idx, mux_out,
    input  sel, busy, done, err, rd_bit, scan_word
  );

  modport slave (
    input  start, mode, ch_idx, mux_out,
    output sel, busy, done, err, rd_bit, scan_word
  );
endinterface

// File: rtl/mux29_sel_enc.sv
// Channel number to tree-mux select code. Channels 0..20 form a regular
// group/remainder grid; 21..28 use fixed codes; anything else maps to 0.
module mux29_sel_enc
  import mux29_pkg::*;
(
  input  logic [CH_W-1:0]  ch,
  output logic [SEL_W-1:0] sel
);
  logic [2:0] grp_s;
  logic [1:0] rem_s;

  // Group of three leaves picks the first-level mux; remainder picks the leaf
  always_comb begin
    grp_s = 3'(ch / 5'd3);
    rem_s = 2'(ch % 5'd3);
    sel   = 8'h00;
    case (ch)
      5'd21:   sel = SEL_CH21;
      5'd22:   sel = SEL_CH22;
      5'd23:   sel = SEL_CH23;
      5'd24:   sel = SEL_CH24;
      5'd25:   sel = SEL_CH25;
      5'd26:   sel = SEL_CH26;
      5'd27:   sel = SEL_CH27;
      5'd28:   sel = SEL_CH28;
      default: begin
        if (ch < 5'd21) begin
          sel[1:0] = rem_s;
          sel[2]   = grp_s[0];
          sel[4]   = grp_s[1];
          sel[6]   = grp_s[2];
        end else begin
          sel = 8'h00;
        end
      end
    endcase
  end
endmodule

// File: rtl/mux29_scan_ctrl.sv
// Sequencer driving the 29:1 tree-mux select: single-channel reads or a full
// 29-channel scan, with a settle delay before each sample of mux_out.
module mux29_scan_ctrl
  import mux29_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  mux29_scan_ctrl_if.slave bus
);
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_bit_q, rd_bit_d;
  logic [NUM_CH-1:0] scan_word_q, scan_word_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              scan_q, scan_d;
  logic              inv_q, inv_d;
  logic [CH_W-1:0]   enc_ch_s;
  logic [SEL_W-1:0]  enc_sel_s;
  logic              req_bad_s;

  mux29_sel_enc u_enc (
    .ch  (enc_ch_s),
    .sel (enc_sel_s)
  );

  // Channel whose code may be loaded next: the request's first channel, or the scan successor
  always_comb begin
    req_bad_s = !bus.mode && (bus.ch_idx > LAST_CH);
    if (state_q == ST_IDLE) begin
      if (bus.mode) begin
        enc_ch_s = 5'd0;
      end else begin
        enc_ch_s = bus.ch_idx;
      end
    end else begin
      enc_ch_s = ch_q + 5'd1;
    end
  end

  // Next-state and output logic; FINISH spends one cycle before raising done so
  // that done, busy=0 and scan_word appear together while start is still refused
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rd_bit_d    = rd_bit_q;
    scan_word_d = scan_word_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    scan_d      = scan_q;
    inv_d       = inv_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          scan_d = bus.mode;
          inv_d  = req_bad_s;
          if (req_bad_s) begin
            state_d = ST_FINISH;
          end else begin
            ch_d    = enc_ch_s;
            sel_d   = enc_sel_s;
            cnt_d   = 4'd1;
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          if (scan_q) begin
            shadow_d[ch_q] = bus.mux_out;
            if (ch_q == LAST_CH) begin
              state_d = ST_FINISH;
            end else begin
              ch_d  = enc_ch_s;
              sel_d = enc_sel_s;
              cnt_d = 4'd1;
            end
          end else begin
            rd_bit_d = bus.mux_out;
            state_d  = ST_FINISH;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_FINISH: begin
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          err_d  = inv_q;
          if (scan_q) begin
            scan_word_d = shadow_q;
          end else begin
            scan_word_d = scan_word_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_bit_q    <= 1'b0;
      scan_word_q <= 29'd0;
      shadow_q    <= 29'd0;
      cnt_q       <= 4'd0;
      ch_q        <= 5'd0;
      scan_q      <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_bit_q    <= rd_bit_d;
      scan_word_q <= scan_word_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      scan_q      <= scan_d;
      inv_q       <= inv_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_bit    = rd_bit_q;
  assign bus.scan_word = scan_word_q;
endmodule

// File: tb/tb_mux29_scan_ctrl.sv
// Bench for mux29_scan_ctrl: two controllers (settle 1 and 2) each in front of
// a behavioural 29:1 tree model, plus a standalone encoder instance.
module tb_mux29_scan_ctrl;
  import mux29_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux29_scan_ctrl_if ifa ();
  mux29_scan_ctrl_if ifb ();

  logic [28:0] tree_a, tree_b;
  logic [4:0]  enc_ch;
  logic [7:0]  enc_sel;

  int errors = 0;
  int checks = 0;

  // Model state for the settle-1 controller's held outputs
  int   last_ch_a;
  logic last_rd_a;

  logic [7:0] sel_log [0:127];
  int         log_n;
  bit         sw_moved;

  mux29_scan_ctrl #(.SETTLE_CYC(1)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  mux29_scan_ctrl #(.SETTLE_CYC(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  mux29_sel_enc u_enc (.ch(enc_ch), .sel(enc_sel));

  // Tree model: which channel a select code routes to (-1 = none)
  function automatic int tree_ch(input logic [7:0] s);
    int g, r;
    case (s)
      8'h80: return 28;
      8'h60: return 27;
      8'h20: return 26;
      8'h58: return 25;
      8'h54: return 24;
      8'h48: return 23;
      8'h18: return 22;
      8'h08: return 21;
      default: ;
    endcase
    if (s[7] | s[5] | s[3]) return -1;
    g = {29'd0, s[6], s[4], s[2]};
    r = {30'd0, s[1:0]};
    if (r == 3) return -1;
    if (3 * g + r > 20) return -1;
    return 3 * g + r;
  endfunction

  function automatic logic tree_out(input logic [28:0] v, input logic [7:0] s);
    int c;
    c = tree_ch(s);
    if (c < 0) return 1'b0;
    return v[c];
  endfunction

  assign ifa.mux_out = tree_out(tree_a, ifa.sel);
  assign ifb.mux_out = tree_out(tree_b, ifb.sel);

  task automatic drive(input int which, input logic s, input logic m, input logic [4:0] c);
    if (which == 0) begin
      ifa.start = s; ifa.mode = m; ifa.ch_idx = c;
    end else begin
      ifb.start = s; ifb.mode = m; ifb.ch_idx = c;
    end
  endtask

  // Pulse start for one edge, then log per-cycle outputs until done (bounded).
  // Cycle n is observed at the falling edge after E0+n.
  task automatic do_op(input int which, input logic m, input logic [4:0] c,
                       output int done_n, output int busy_n);
    logic [7:0]  s;
    logic        b, d;
    logic [28:0] w, w0;
    @(negedge clk); drive(which, 1'b1, m, c);
    @(negedge clk); drive(which, 1'b0, m, c);
    done_n = -1; busy_n = 0; log_n = 0; sw_moved = 1'b0; w0 = 29'd0;
    for (int n = 0; n < 200; n++) begin
      s = (which == 0) ? ifa.sel  : ifb.sel;
      b = (which == 0) ? ifa.busy : ifb.busy;
      d = (which == 0) ? ifa.done : ifb.done;
      w = (which == 0) ? ifa.scan_word : ifb.scan_word;
      if (n == 0) w0 = w;
      if (log_n < 128) begin sel_log[log_n] = s; log_n++; end
      if (b) busy_n++;
      if (d) begin done_n = n; break; end
      if (w !== w0) sw_moved = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 5'd0);
    drive(1, 1'b0, 1'b0, 5'd0);
    tree_a = 29'($urandom);
    tree_b = 29'($urandom);
    repeat (2) @(negedge clk);
    checks++; if (ifa.sel !== 8'h00 || ifb.sel !== 8'h00) begin errors++; $display("FAIL reset_sel got %0h/%0h want 0", ifa.sel, ifb.sel); end
    checks++; if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0 || ifa.done !== 1'b0 || ifb.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b%b%b want 0000", ifa.busy, ifb.busy, ifa.done, ifb.done); end
    checks++; if (ifa.err !== 1'b0 || ifa.rd_bit !== 1'b0 || ifb.err !== 1'b0 || ifb.rd_bit !== 1'b0) begin errors++; $display("FAIL reset_err_rd got %b%b%b%b want 0000", ifa.err, ifa.rd_bit, ifb.err, ifb.rd_bit); end
    checks++; if (ifa.scan_word !== 29'd0 || ifb.scan_word !== 29'd0) begin errors++; $display("FAIL reset_scan_word got %0h/%0h want 0", ifa.scan_word, ifb.scan_word); end
    rst = 1'b0;
    last_ch_a = 0;
    last_rd_a = 1'b0;
  endtask

  task automatic test_encoder_sweep;
    logic [28:0] onehot;
    for (int k = 0; k < 29; k++) begin
      enc_ch = 5'(k);
      onehot = 29'd1 << k;
      #1;
      checks++;
      if (tree_out(onehot, enc_sel) !== 1'b1) begin errors++; $display("FAIL enc_sweep ch=%0d got sel=%0h want routing to ch %0d", k, enc_sel, k); end
    end
    enc_ch = 5'd4;  #1; checks++; if (enc_sel !== 8'h05) begin errors++; $display("FAIL enc4 got %0h want 05", enc_sel); end
    enc_ch = 5'd24; #1; checks++; if (enc_sel !== 8'h54) begin errors++; $display("FAIL enc24 got %0h want 54", enc_sel); end
    enc_ch = 5'd28; #1; checks++; if (enc_sel !== 8'h80) begin errors++; $display("FAIL enc28 got %0h want 80", enc_sel); end
    enc_ch = 5'd20; #1; checks++; if (enc_sel !== 8'h52) begin errors++; $display("FAIL enc20 got %0h want 52", enc_sel); end
  endtask

  task automatic test_single_read;
    int dn, bn;
    tree_a = 29'h1C71C71C;
    do_op(0, 1'b0, 5'd4, dn, bn);
    checks++; if (sel_log[0] !== 8'h05) begin errors++; $display("FAIL single_sel got %0h want 05", sel_log[0]); end
    checks++; if (dn !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", dn); end
    checks++; if (bn !== 2) begin errors++; $display("FAIL single_busy_cycles got %0d want 2", bn); end
    checks++; if (ifa.rd_bit !== 1'b1 || ifa.err !== 1'b0) begin errors++; $display("FAIL single_result got rd=%b err=%b want rd=1 err=0", ifa.rd_bit, ifa.err); end
    @(negedge clk);
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", ifa.done); end
    last_ch_a = 4;
    last_rd_a = 1'b1;
  endtask

  task automatic test_invalid_channel;
    int dn, bn;
    tree_a = 29'($urandom);
    do_op(0, 1'b0, 5'd30, dn, bn);
    checks++; if (dn !== 1) begin errors++; $display("FAIL invalid_latency got %0d want 1", dn); end
    checks++; if (ifa.err !== 1'b1) begin errors++; $display("FAIL invalid_err got %b want 1", ifa.err); end
    checks++; if (ifa.rd_bit !== last_rd_a) begin errors++; $display("FAIL invalid_rd_hold got %b want %b", ifa.rd_bit, last_rd_a); end
    checks++; if (tree_ch(ifa.sel) != last_ch_a) begin errors++; $display("FAIL invalid_sel_hold got ch %0d want ch %0d", tree_ch(ifa.sel), last_ch_a); end
  endtask

  task automatic test_random_single;
    int dn, bn;
    logic [4:0] c;
    for (int i = 0; i < 16; i++) begin
      c = 5'($urandom_range(0, 31));
      tree_a = 29'($urandom);
      do_op(0, 1'b0, c, dn, bn);
      if (c <= 5'd28) begin
        last_ch_a = int'(c);
        last_rd_a = tree_a[c];
      end
      checks++;
      if (dn !== ((c <= 5'd28) ? 2 : 1) || ifa.err !== (c > 5'd28) || ifa.rd_bit !== last_rd_a || tree_ch(ifa.sel) != last_ch_a) begin
        errors++;
        $display("FAIL rand_single ch=%0d got lat=%0d err=%b rd=%b selch=%0d want err=%b rd=%b selch=%0d",
                 c, dn, ifa.err, ifa.rd_bit, tree_ch(ifa.sel), (c > 5'd28), last_rd_a, last_ch_a);
      end
    end
  endtask

  task automatic test_full_scan;
    int dn, bn, bad;
    tree_b = 29'h0A5A5A5A;
    do_op(1, 1'b1, 5'd0, dn, bn);
    checks++; if (dn !== 59) begin errors++; $display("FAIL scan_latency got %0d want 59", dn); end
    checks++; if (bn !== 59) begin errors++; $display("FAIL scan_busy_cycles got %0d want 59", bn); end
    checks++; if (ifb.scan_word !== 29'h0A5A5A5A) begin errors++; $display("FAIL scan_word got %0h want 0a5a5a5a", ifb.scan_word); end
    checks++; if (sw_moved || sel_log[0] === 8'hxx) begin errors++; $display("FAIL scan_word_early got moved=%b want 0", sw_moved); end
    bad = -1;
    for (int k = 0; k < 29; k++) begin
      if (bad < 0 && (tree_ch(sel_log[2*k]) != k || tree_ch(sel_log[2*k+1]) != k)) bad = k;
    end
    checks++; if (bad != -1) begin errors++; $display("FAIL scan_sel_walk got wrong code at ch %0d (sel=%0h) want each ch held 2 cycles", bad, sel_log[2*bad]); end
    @(negedge clk);
    checks++; if (ifb.done !== 1'b0) begin errors++; $display("FAIL scan_done_pulse got %b want 0", ifb.done); end
    tree_b = 29'($urandom);
    do_op(1, 1'b1, 5'd0, dn, bn);
    checks++; if (dn !== 59 || ifb.scan_word !== tree_b) begin errors++; $display("FAIL scan_random got lat=%0d word=%0h want 59 %0h", dn, ifb.scan_word, tree_b); end
  endtask

  task automatic test_start_while_busy;
    int dn;
    tree_b = 29'($urandom);
    @(negedge clk); drive(1, 1'b1, 1'b1, 5'd0);
    @(negedge clk); drive(1, 1'b0, 1'b1, 5'd0);
    repeat (10) @(negedge clk);
    drive(1, 1'b1, 1'b0, 5'd3);
    @(negedge clk); drive(1, 1'b0, 1'b0, 5'd3);
    dn = -1;
    for (int n = 11; n < 200; n++) begin
      if (ifb.done) begin dn = n; break; end
      @(negedge clk);
    end
    checks++; if (dn !== 59 || ifb.scan_word !== tree_b) begin errors++; $display("FAIL busy_start got lat=%0d word=%0h want 59 %0h", dn, ifb.scan_word, tree_b); end
    // Raise start in the done cycle and hold it one more cycle
    drive(1, 1'b1, 1'b0, 5'd7);
    @(negedge clk);
    checks++; if (ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin errors++; $display("FAIL finish_start got busy=%b done=%b want 0 0", ifb.busy, ifb.done); end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 5'd7);
    checks++; if (ifb.busy !== 1'b1 || tree_ch(ifb.sel) != 7) begin errors++; $display("FAIL late_accept got busy=%b selch=%0d want 1 7", ifb.busy, tree_ch(ifb.sel)); end
    dn = -1;
    for (int n = 0; n < 20; n++) begin
      if (ifb.done) begin dn = n; break; end
      @(negedge clk);
    end
    checks++; if (dn !== 3 || ifb.rd_bit !== tree_b[7]) begin errors++; $display("FAIL late_read got lat=%0d rd=%b want 3 %b", dn, ifb.rd_bit, tree_b[7]); end
  endtask

  task automatic test_reset_mid_scan;
    int dn, bn;
    bit seen, reached;
    tree_b = 29'($urandom);
    @(negedge clk); drive(1, 1'b1, 1'b1, 5'd0);
    @(negedge clk); drive(1, 1'b0, 1'b1, 5'd0);
    reached = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (tree_ch(ifb.sel) == 10) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin errors++; $display("FAIL mid_scan_reach got no ch 10 want ch 10 within 100 cycles"); end
    rst = 1'b1;
    #1;
    checks++; if (ifb.sel !== 8'h00 || ifb.busy !== 1'b0 || ifb.done !== 1'b0 || ifb.scan_word !== 29'd0) begin
      errors++; $display("FAIL mid_reset got sel=%0h busy=%b done=%b word=%0h want 0 0 0 0", ifb.sel, ifb.busy, ifb.done, ifb.scan_word);
    end
    @(negedge clk);
    rst = 1'b0;
    last_ch_a = 0;
    last_rd_a = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (ifb.done || ifb.busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL post_reset_quiet got activity want none"); end
    do_op(1, 1'b1, 5'd0, dn, bn);
    checks++; if (dn !== 59 || ifb.scan_word !== tree_b) begin errors++; $display("FAIL post_reset_scan got lat=%0d word=%0h want 59 %0h", dn, ifb.scan_word, tree_b); end
  endtask

  initial begin
    rst = 1'b1;
    enc_ch = 5'd0;
    tree_a = 29'd0;
    tree_b = 29'd0;
    drive(0, 1'b0, 1'b0, 5'd0);
    drive(1, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_encoder_sweep();
    test_full_scan();
    test_single_read();
    test_invalid_channel();
    test_random_single();
    test_start_while_busy();
    test_reset_mid_scan();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
